// File: rtl/gf_muls_2_masked_sched_pkg.sv
// Shared types and helpers for the masked GF(2^2) datapath.
//   gf2_t          : one GF(2^2) element in normal basis [Omega^2, Omega]
//   sched_state_t  : states of the multiplier scheduler
//   gf2_sum3       : expands a 2-bit share into the leaf operand format {hi^lo, hi, lo}
package aes_mask_pkg;

  typedef logic [1:0] gf2_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M00  = 3'd1,
    M01  = 3'd2,
    M10  = 3'd3,
    M11  = 3'd4,
    RESP = 3'd5
  } sched_state_t;

  function automatic logic [2:0] gf2_sum3(gf2_t s);
    return {^s, s};
  endfunction

endpackage

// File: rtl/gf_muls_2_masked_sched_if.sv
// Requester / randomness / response bundle of the masked multiplier scheduler.
//   req_valid/req_ready : per-requester job handshake (ready is one-hot)
//   req_x0..req_y1      : 2-bit operand shares, requester i at [2i+1:2i]
//   rnd_valid/rnd/rnd_ready : fresh 2-bit refresh mask
//   rsp_valid/rsp_ready : result handshake; rsp_id names the owning requester
//   rsp_z0/rsp_z1       : result shares
// master = requester/mask side, slave = scheduler side.
interface gf_muls_2_masked_sched_if
  import aes_mask_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_x0;
  logic [2*NREQ-1:0] req_x1;
  logic [2*NREQ-1:0] req_y0;
  logic [2*NREQ-1:0] req_y1;
  logic              rnd_valid;
  gf2_t              rnd;
  logic              rnd_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  gf2_t              rsp_z0;
  gf2_t              rsp_z1;

  modport master (
    output req_valid, req_x0, req_x1, req_y0, req_y1, rnd_valid, rnd, rsp_ready,
    input  req_ready, rnd_ready, rsp_valid, rsp_id, rsp_z0, rsp_z1
  );

  modport slave (
    input  req_valid, req_x0, req_x1, req_y0, req_y1, rnd_valid, rnd, rsp_ready,
    output req_ready, rnd_ready, rsp_valid, rsp_id, rsp_z0, rsp_z1
  );

endinterface

// File: rtl/gf_muls_2_masked_sched_mul.sv
// GF(2^2) multiplier leaf, normal basis [Omega^2, Omega].
//   a, b : operands in {hi^lo, hi, lo} format (bit-sum supplied by the caller
//          from a registered share, so no share recombination happens here)
//   p    : product a*b
module gf_muls_2_masked
  import aes_mask_pkg::*;
(
  input  logic [2:0] a,
  input  logic [2:0] b,
  output gf2_t       p
);

  logic sum_term;

  // The bit-sum cross product is common to both output bits.
  assign sum_term = a[2] & b[2];
  assign p        = {(a[1] & b[1]) ^ sum_term, (a[0] & b[0]) ^ sum_term};

endmodule

// File: rtl/gf_muls_2_masked_sched.sv
// Round-robin scheduler sharing one masked GF(2^2) multiplier among NREQ requesters.
// Each job computes z0^z1 = (x0^x1)*(y0^y1) as four share products with the cross
// terms refreshed by one fresh mask r (ISW):
//   z0 = x0*y0 ^ r,   z1 = ((x0*y1 ^ r) ^ x1*y0) ^ x1*y1
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : requester / mask / response bundle (slave side)
module gf_muls_2_masked_sched
  import aes_mask_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  gf_muls_2_masked_sched_if.slave   bus
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_M00  = M00;
  localparam logic [2:0] ST_M01  = M01;
  localparam logic [2:0] ST_M10  = M10;
  localparam logic [2:0] ST_M11  = M11;
  localparam logic [2:0] ST_RESP = RESP;

  logic [2:0]      state;
  logic [ID_W-1:0] ptr;
  gf2_t            x0_q, x1_q, y0_q, y1_q, r_q;
  gf2_t            acc0, acc1;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  gf2_t            rsp_z0_q, rsp_z1_q;

  logic            found;
  logic [ID_W-1:0] winner;
  logic            grant;
  gf2_t            sel_x, sel_y, p;

  // Round-robin search starting just after the last winner.
  always_comb begin
    // NOTE: every combinational output is given a default first so no path leaves it unassigned.
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // No grant without fresh randomness; reset also suppresses it.
  assign grant         = rst_n && (state == ST_IDLE) && found && bus.rnd_valid;
  assign bus.rnd_ready = grant;

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready = NREQ'(1) << winner;
  end

  // Operand select is a function of the registered state only, so the leaf sees
  // stable registered shares for a whole cycle.
  always_comb begin
    sel_x = x0_q;
    sel_y = y0_q;
    case (state)
      ST_M01: sel_y = y1_q;
      ST_M10: sel_x = x1_q;
      ST_M11: begin
        sel_x = x1_q;
        sel_y = y1_q;
      end
      default: ;
    endcase
  end

  gf_muls_2_masked u_mul (
    .a (gf2_sum3(sel_x)),
    .b (gf2_sum3(sel_y)),
    .p (p)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= ID_W'(NREQ - 1);
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      r_q         <= '0;
      acc0        <= '0;
      acc1        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z0_q    <= '0;
      rsp_z1_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            x0_q     <= bus.req_x0[2*int'(winner) +: 2];
            x1_q     <= bus.req_x1[2*int'(winner) +: 2];
            y0_q     <= bus.req_y0[2*int'(winner) +: 2];
            y1_q     <= bus.req_y1[2*int'(winner) +: 2];
            r_q      <= bus.rnd;
            rsp_id_q <= winner;
            ptr      <= winner;
            state    <= ST_M00;
          end
        end
        ST_M00: begin
          acc0  <= p ^ r_q;
          state <= ST_M01;
        end
        // The masked x0*y1 term must be folded into acc1 before any x1 product.
        ST_M01: begin
          acc1  <= p ^ r_q;
          state <= ST_M10;
        end
        ST_M10: begin
          acc1  <= acc1 ^ p;
          state <= ST_M11;
        end
        ST_M11: begin
          acc1        <= acc1 ^ p;
          rsp_z0_q    <= acc0;
          rsp_z1_q    <= acc1 ^ p;
          rsp_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z0    = rsp_z0_q;
  assign bus.rsp_z1    = rsp_z1_q;

endmodule
